// File: rtl/vga_frame_reader_if.sv
// Video RAM read port and VGA connector signals of the frame reader.
// The reader is the master; the RAM/pin side is the slave.
interface vga_frame_reader_if;
  logic [2:0]  read_data;
  logic [15:0] read_address;
  logic        read_enable;
  logic        vga_r;
  logic        vga_g;
  logic        vga_b;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    input  read_data,
    output read_address, read_enable, vga_r, vga_g, vga_b, hsync, vsync, frame_start
  );

  modport slave (
    output read_data,
    input  read_address, read_enable, vga_r, vga_g, vga_b, hsync, vsync, frame_start
  );
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan of a 256x256 3-bit frame buffer through a synchronous read port.
// Optional macro VGA_BORDER_EN draws a white 1-pixel frame around the window.
module vga_frame_reader #(
  parameter int          CLK_DIV  = 2,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          WIN_X    = 0,
  parameter int          WIN_Y    = 0,
  parameter logic [2:0]  BG_COLOR = 3'b000
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_frame_reader_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  typedef logic [9:0] cnt_t;

  logic [DIV_W-1:0] div;
  logic             tick;
  cnt_t             hcnt, vcnt, dx, dy;
  logic             active, inwin, border, hs, vs;
  logic             s1_inwin, s1_active, s1_border, s1_hs, s1_vs;
  logic [2:0]       pix;

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      if (hcnt == cnt_t'(H_TOTAL - 1)) begin
        hcnt <= '0;
        vcnt <= (vcnt == cnt_t'(V_TOTAL - 1)) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Modulo-1024 offsets: anything left of/above the window wraps high and fails the [0,255] test.
  assign dx     = hcnt - cnt_t'(WIN_X);
  assign dy     = vcnt - cnt_t'(WIN_Y);
  assign active = (hcnt < cnt_t'(H_ACTIVE)) && (vcnt < cnt_t'(V_ACTIVE));
  assign inwin  = active && (dx[9:8] == 2'b00) && (dy[9:8] == 2'b00);
  assign hs     = !((hcnt >= cnt_t'(H_ACTIVE + H_FP)) && (hcnt < cnt_t'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs     = !((vcnt >= cnt_t'(V_ACTIVE + V_FP)) && (vcnt < cnt_t'(V_ACTIVE + V_FP + V_SYNC)));

`ifdef VGA_BORDER_EN
  cnt_t bx, by;
  logic on_col, on_row;
  assign bx     = hcnt - cnt_t'(WIN_X - 1);
  assign by     = vcnt - cnt_t'(WIN_Y - 1);
  assign on_col = (hcnt == cnt_t'(WIN_X - 1)) || (hcnt == cnt_t'(WIN_X + 256));
  assign on_row = (vcnt == cnt_t'(WIN_Y - 1)) || (vcnt == cnt_t'(WIN_Y + 256));
  assign border = active && !inwin && ((on_col && by <= 10'd257) || (on_row && bx <= 10'd257));
`else
  assign border = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inwin         <= 1'b0;
      s1_active        <= 1'b0;
      s1_border        <= 1'b0;
      s1_hs            <= 1'b1;
      s1_vs            <= 1'b1;
      vga.read_enable  <= 1'b0;
      vga.read_address <= '0;
    end else if (tick) begin
      s1_inwin        <= inwin;
      s1_active       <= active;
      s1_border       <= border;
      s1_hs           <= hs;
      s1_vs           <= vs;
      vga.read_enable <= inwin;
      if (inwin) vga.read_address <= {dy[7:0], dx[7:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vga.frame_start <= 1'b0;
    else        vga.frame_start <= tick && (hcnt == '0) && (vcnt == '0);
  end

  // RAM data fetched for the stage-1 address is sampled one tick later.
  always_comb begin
    pix = 3'b000;
    if (s1_inwin)       pix = vga.read_data;
    else if (s1_border) pix = 3'b111;
    else if (s1_active) pix = BG_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vga.vga_r, vga.vga_g, vga.vga_b} <= 3'b000;
      vga.hsync <= 1'b1;
      vga.vsync <= 1'b1;
    end else if (tick) begin
      {vga.vga_r, vga.vga_g, vga.vga_b} <= pix;
      vga.hsync <= s1_hs;
      vga.vsync <= s1_vs;
    end
  end

endmodule
